// File: rtl/clock_set_pkg.sv
// Shared definitions for the clock time-entry front end: FSM state encoding,
// field selector codes, BCD limits and the BCD field arithmetic helpers.
`timescale 1ns/1ps
package clock_set_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_COMMIT  = 3'd4
  } state_t;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HR   = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_SEC  = 2'd3;

  localparam logic [7:0] HR_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  // Two-digit BCD increment with wrap to 00 once max_val is reached.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
    logic [7:0] res;
    if (val >= max_val) begin
      res = 8'h00;
    end else if (val[3:0] >= 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

  // Two-digit BCD decrement with wrap from 00 to max_val.
  function automatic logic [7:0] bcd_dec(input logic [7:0] val, input logic [7:0] max_val);
    logic [7:0] res;
    if (val == 8'h00) begin
      res = max_val;
    end else if (val[3:0] == 4'd0) begin
      res = {val[7:4] - 4'd1, 4'd9};
    end else begin
      res = {val[7:4], val[3:0] - 4'd1};
    end
    return res;
  endfunction

  // True when every digit is in range and hours do not exceed 23.
  function automatic logic time_valid(input logic [23:0] t);
    logic ok;
    ok = (t[23:20] <= 4'd2) && (t[19:16] <= 4'd9) &&
         (t[15:12] <= 4'd5) && (t[11:8]  <= 4'd9) &&
         (t[7:4]   <= 4'd5) && (t[3:0]   <= 4'd9) &&
         (t[23:16] <= HR_MAX);
    return ok;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle pulse on every accepted rising level.
`timescale 1ns/1ps
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  logic        sync1_r;
  logic        sync2_r;
  logic        level_r;
  logic        press_r;
  logic [15:0] cnt_r;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after enough consecutive differing samples; pulse on accepted 0->1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= 1'b0;
      cnt_r   <= 16'd0;
      press_r <= 1'b0;
    end else if (sync2_r == level_r) begin
      cnt_r   <= 16'd0;
      press_r <= 1'b0;
    end else if (cnt_r >= DEBOUNCE_CYCLES - 16'd1) begin
      level_r <= sync2_r;
      cnt_r   <= 16'd0;
      press_r <= sync2_r;
    end else begin
      cnt_r   <= cnt_r + 16'd1;
      press_r <= 1'b0;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/clock_time_setter.sv
// Time-entry front end for the 24-hour BCD clock: snapshots the running time,
// lets the user edit hours/minutes/seconds and commits with a Set_time strobe.
// Optional decrement button support is enabled by defining CLOCK_SET_DEC_EN.
`timescale 1ns/1ps
module clock_time_setter
  import clock_set_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000,
  parameter logic [31:0] BLINK_CYCLES    = 32'd25000000
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        Btn_mode,
  input  logic        Btn_inc,
  input  logic        Btn_dec,
  input  logic [23:0] Time_now,
  output logic [23:0] Time_in,
  output logic        Set_time,
  output logic        Edit_active,
  output logic [1:0]  Field_sel,
  output logic        Blink
);

  state_t      state_r, next_state_s;
  logic [23:0] time_in_r, time_next_s;
  logic        set_time_r, edit_r, blink_r;
  logic [1:0]  field_r, field_next_s;
  logic        edit_next_s;
  logic [31:0] tmo_cnt_r, blink_cnt_r;
  logic        mode_p_s, inc_p_s, inc_ok_s, any_p_s, tmo_hit_s;
  logic [7:0]  field_val_s, field_max_s, field_new_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk(CLK), .rst_n(Reset_n), .btn_raw(Btn_mode), .press(mode_p_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk(CLK), .rst_n(Reset_n), .btn_raw(Btn_inc), .press(inc_p_s)
  );

`ifdef CLOCK_SET_DEC_EN
  logic dec_p_s, dec_ok_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_db (
    .clk(CLK), .rst_n(Reset_n), .btn_raw(Btn_dec), .press(dec_p_s)
  );

  // Mode wins over inc/dec; inc and dec together cancel each other.
  assign inc_ok_s = inc_p_s & ~dec_p_s & ~mode_p_s;
  assign dec_ok_s = dec_p_s & ~inc_p_s & ~mode_p_s;
  assign any_p_s  = mode_p_s | inc_p_s | dec_p_s;
`else
  logic unused_dec_s;
  assign unused_dec_s = Btn_dec;
  assign inc_ok_s     = inc_p_s & ~mode_p_s;
  assign any_p_s      = mode_p_s | inc_p_s;
`endif

  assign tmo_hit_s = (tmo_cnt_r == TIMEOUT_CYCLES - 32'd1) & ~any_p_s;

  // Select the edited field and compute its adjusted BCD value.
  always_comb begin
    field_val_s = 8'h00;
    field_max_s = HR_MAX;
    case (state_r)
      ST_SET_HR:  begin field_val_s = time_in_r[23:16]; field_max_s = HR_MAX; end
      ST_SET_MIN: begin field_val_s = time_in_r[15:8];  field_max_s = MS_MAX; end
      ST_SET_SEC: begin field_val_s = time_in_r[7:0];   field_max_s = MS_MAX; end
      default:    begin field_val_s = 8'h00;            field_max_s = HR_MAX; end
    endcase
    field_new_s = field_val_s;
    if (inc_ok_s) begin
      field_new_s = bcd_inc(field_val_s, field_max_s);
    end
`ifdef CLOCK_SET_DEC_EN
    else if (dec_ok_s) begin
      field_new_s = bcd_dec(field_val_s, field_max_s);
    end
`endif
    else begin
      field_new_s = field_val_s;
    end
  end

  // Next-state and next-value logic for the edit FSM.
  always_comb begin
    next_state_s = state_r;
    time_next_s  = time_in_r;
    case (state_r)
      ST_IDLE: begin
        if (mode_p_s) begin
          next_state_s = ST_SET_HR;
          time_next_s  = time_valid(Time_now) ? Time_now : 24'h000000;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SET_HR: begin
        if (mode_p_s) begin
          next_state_s = ST_SET_MIN;
        end else if (tmo_hit_s) begin
          next_state_s = ST_IDLE;
        end else begin
          time_next_s = {field_new_s, time_in_r[15:0]};
        end
      end
      ST_SET_MIN: begin
        if (mode_p_s) begin
          next_state_s = ST_SET_SEC;
        end else if (tmo_hit_s) begin
          next_state_s = ST_IDLE;
        end else begin
          time_next_s = {time_in_r[23:16], field_new_s, time_in_r[7:0]};
        end
      end
      ST_SET_SEC: begin
        if (mode_p_s) begin
          next_state_s = ST_COMMIT;
        end else if (tmo_hit_s) begin
          next_state_s = ST_IDLE;
        end else begin
          time_next_s = {time_in_r[23:8], field_new_s};
        end
      end
      ST_COMMIT: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Decode the upcoming state into field selector and edit flag so they register alongside it.
  always_comb begin
    field_next_s = FLD_NONE;
    edit_next_s  = 1'b0;
    case (next_state_s)
      ST_SET_HR:  begin field_next_s = FLD_HR;   edit_next_s = 1'b1; end
      ST_SET_MIN: begin field_next_s = FLD_MIN;  edit_next_s = 1'b1; end
      ST_SET_SEC: begin field_next_s = FLD_SEC;  edit_next_s = 1'b1; end
      default:    begin field_next_s = FLD_NONE; edit_next_s = 1'b0; end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered outputs: edited time, commit strobe, edit flag and field selector.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      time_in_r  <= 24'h000000;
      set_time_r <= 1'b0;
      edit_r     <= 1'b0;
      field_r    <= FLD_NONE;
    end else begin
      time_in_r  <= time_next_s;
      set_time_r <= (next_state_s == ST_COMMIT);
      edit_r     <= edit_next_s;
      field_r    <= field_next_s;
    end
  end

  // Inactivity counter: restarts on any button pulse, any state change, and outside editing.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      tmo_cnt_r <= 32'd0;
    end else if ((next_state_s != state_r) || any_p_s || !edit_next_s) begin
      tmo_cnt_r <= 32'd0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end
  end

  // Blink generator: starts high on entering edit, toggles every BLINK_CYCLES, held low otherwise.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_r     <= 1'b0;
      blink_cnt_r <= 32'd0;
    end else if (!edit_next_s) begin
      blink_r     <= 1'b0;
      blink_cnt_r <= 32'd0;
    end else if (state_r == ST_IDLE) begin
      blink_r     <= 1'b1;
      blink_cnt_r <= 32'd0;
    end else if (blink_cnt_r >= BLINK_CYCLES - 32'd1) begin
      blink_r     <= ~blink_r;
      blink_cnt_r <= 32'd0;
    end else begin
      blink_cnt_r <= blink_cnt_r + 32'd1;
    end
  end

  assign Time_in     = time_in_r;
  assign Set_time    = set_time_r;
  assign Edit_active = edit_r;
  assign Field_sel   = field_r;
  assign Blink       = blink_r;

endmodule

// File: tb/tb_clock_time_setter.sv
// Directed self-checking bench for clock_time_setter (debounce 4, timeout 64, blink 8).
`timescale 1ns/1ps
module tb_clock_time_setter;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Btn_mode = 1'b0;
  logic        Btn_inc = 1'b0;
  logic        Btn_dec = 1'b0;
  logic [23:0] Time_now = 24'h000000;
  logic [23:0] Time_in;
  logic        Set_time;
  logic        Edit_active;
  logic [1:0]  Field_sel;
  logic        Blink;

  int checks = 0;
  int errors = 0;
  int set_count = 0;
  int set_before = 0;

  clock_time_setter #(
    .DEBOUNCE_CYCLES(16'd4),
    .TIMEOUT_CYCLES(32'd64),
    .BLINK_CYCLES(32'd8)
  ) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Btn_mode(Btn_mode), .Btn_inc(Btn_inc),
    .Btn_dec(Btn_dec), .Time_now(Time_now), .Time_in(Time_in), .Set_time(Set_time),
    .Edit_active(Edit_active), .Field_sel(Field_sel), .Blink(Blink)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (Set_time === 1'b1) set_count++;
  end

  // Raise buttons; returns at the negedge right after the FSM reacted to the pulse.
  task automatic btn_down(input logic m, input logic i, input logic d);
    @(negedge CLK);
    Btn_mode = m; Btn_inc = i; Btn_dec = d;
    repeat (7) @(posedge CLK);
    @(negedge CLK);
  endtask

  // Release all buttons and let the release debounce out.
  task automatic btn_up();
    Btn_mode = 1'b0; Btn_inc = 1'b0; Btn_dec = 1'b0;
    repeat (8) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    btn_down(m, i, d);
    btn_up();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({Time_in, Set_time, Edit_active, Field_sel, Blink} !== 29'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {Time_in, Set_time, Edit_active, Field_sel, Blink});
    end
    Reset_n = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_enter_edit();
    Time_now = 24'h123456;
    btn_down(1'b1, 1'b0, 1'b0);
    checks++;
    if (Time_in !== 24'h123456) begin errors++; $display("FAIL enter_time_in: got %h expected 123456", Time_in); end
    checks++;
    if (Field_sel !== 2'd1) begin errors++; $display("FAIL enter_field: got %0d expected 1", Field_sel); end
    checks++;
    if (Edit_active !== 1'b1) begin errors++; $display("FAIL enter_edit_active: got %b expected 1", Edit_active); end
    checks++;
    if (Blink !== 1'b1) begin errors++; $display("FAIL enter_blink: got %b expected 1", Blink); end
    btn_up();
    checks++;
    if (Blink !== 1'b0) begin errors++; $display("FAIL blink_toggle: got %b expected 0", Blink); end
  endtask

  task automatic test_bounce_and_wrap();
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); Btn_inc = 1'b1;
      @(negedge CLK); Btn_inc = 1'b0;
    end
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (Time_in !== 24'h123456) begin errors++; $display("FAIL bounce_ignored: got %h expected 123456", Time_in); end
    for (int k = 0; k < 8; k++) press(1'b0, 1'b1, 1'b0);
    checks++;
    if (Time_in !== 24'h203456) begin errors++; $display("FAIL hour_19_to_20: got %h expected 203456", Time_in); end
    for (int k = 0; k < 3; k++) press(1'b0, 1'b1, 1'b0);
    checks++;
    if (Time_in !== 24'h233456) begin errors++; $display("FAIL hour_23: got %h expected 233456", Time_in); end
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (Time_in !== 24'h003456) begin errors++; $display("FAIL hour_wrap: got %h expected 003456", Time_in); end
  endtask

  task automatic test_full_edit();
    btn_down(1'b1, 1'b0, 1'b0);
    checks++;
    if (Field_sel !== 2'd2) begin errors++; $display("FAIL sel_min: got %0d expected 2", Field_sel); end
    btn_up();
    for (int k = 0; k < 25; k++) press(1'b0, 1'b1, 1'b0);
    checks++;
    if (Time_in !== 24'h005956) begin errors++; $display("FAIL min_59: got %h expected 005956", Time_in); end
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (Time_in !== 24'h000056) begin errors++; $display("FAIL min_wrap: got %h expected 000056", Time_in); end
    btn_down(1'b1, 1'b0, 1'b0);
    checks++;
    if (Field_sel !== 2'd3) begin errors++; $display("FAIL sel_sec: got %0d expected 3", Field_sel); end
    btn_up();
    for (int k = 0; k < 13; k++) press(1'b0, 1'b1, 1'b0);
    checks++;
    if (Time_in !== 24'h000009) begin errors++; $display("FAIL sec_09: got %h expected 000009", Time_in); end
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (Time_in !== 24'h000010) begin errors++; $display("FAIL sec_09_to_10: got %h expected 000010", Time_in); end
    set_before = set_count;
    btn_down(1'b1, 1'b0, 1'b0);
    checks++;
    if (Set_time !== 1'b1) begin errors++; $display("FAIL commit_strobe: got %b expected 1", Set_time); end
    checks++;
    if (Time_in !== 24'h000010) begin errors++; $display("FAIL commit_time: got %h expected 000010", Time_in); end
    checks++;
    if ({Edit_active, Field_sel} !== 3'b000) begin errors++; $display("FAIL commit_flags: got %b expected 000", {Edit_active, Field_sel}); end
    @(posedge CLK); @(negedge CLK);
    checks++;
    if ({Set_time, Edit_active, Field_sel} !== 4'b0000) begin errors++; $display("FAIL after_commit: got %b expected 0000", {Set_time, Edit_active, Field_sel}); end
    btn_up();
    checks++;
    if (set_count !== set_before + 1) begin errors++; $display("FAIL commit_count: got %0d expected %0d", set_count, set_before + 1); end
  endtask

  task automatic test_timeout();
    Time_now = 24'h101010;
    set_before = set_count;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    btn_down(1'b0, 1'b1, 1'b0);
    checks++;
    if (Time_in !== 24'h101110) begin errors++; $display("FAIL timeout_inc_min: got %h expected 101110", Time_in); end
    Btn_inc = 1'b0;
    repeat (63) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (Edit_active !== 1'b1) begin errors++; $display("FAIL timeout_early: got %b expected 1", Edit_active); end
    @(posedge CLK); @(negedge CLK);
    checks++;
    if ({Edit_active, Blink, Field_sel} !== 4'b0000) begin errors++; $display("FAIL timeout_idle: got %b expected 0000", {Edit_active, Blink, Field_sel}); end
    checks++;
    if (Time_in !== 24'h101110) begin errors++; $display("FAIL timeout_retain: got %h expected 101110", Time_in); end
    checks++;
    if (set_count !== set_before) begin errors++; $display("FAIL timeout_no_set: got %0d expected %0d", set_count, set_before); end
  endtask

  task automatic test_invalid_and_priority();
    Time_now = 24'h245960;
    btn_down(1'b1, 1'b0, 1'b0);
    checks++;
    if (Time_in !== 24'h000000) begin errors++; $display("FAIL invalid_capture: got %h expected 000000", Time_in); end
    btn_up();
    btn_down(1'b1, 1'b1, 1'b0);
    checks++;
    if (Field_sel !== 2'd2) begin errors++; $display("FAIL mode_priority_sel: got %0d expected 2", Field_sel); end
    checks++;
    if (Time_in !== 24'h000000) begin errors++; $display("FAIL mode_priority_time: got %h expected 000000", Time_in); end
    btn_up();
  endtask

  task automatic test_async_reset();
    set_before = set_count;
    @(negedge CLK);
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({Time_in, Set_time, Edit_active, Field_sel, Blink} !== 29'h0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", {Time_in, Set_time, Edit_active, Field_sel, Blink});
    end
    @(negedge CLK); Reset_n = 1'b1;
    repeat (4) @(negedge CLK);
    checks++;
    if ({Edit_active, set_count} !== {1'b0, set_before}) begin
      errors++; $display("FAIL post_reset_idle: got edit=%b sets=%0d expected edit=0 sets=%0d", Edit_active, set_count, set_before);
    end
  endtask

`ifdef CLOCK_SET_DEC_EN
  task automatic test_dec();
    Time_now = 24'h005910;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (Time_in !== 24'h235910) begin errors++; $display("FAIL dec_hour_wrap: got %h expected 235910", Time_in); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (Time_in !== 24'h235909) begin errors++; $display("FAIL dec_sec_10_to_09: got %h expected 235909", Time_in); end
    repeat (80) @(posedge CLK);
    @(negedge CLK);
  endtask
`endif

  initial begin
    test_reset();
    test_enter_edit();
    test_bounce_and_wrap();
    test_full_edit();
    test_timeout();
    test_invalid_and_priority();
    test_async_reset();
`ifdef CLOCK_SET_DEC_EN
    test_dec();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_time_setter.md
Name: clock_time_setter

Overview:
User time-entry front end that sits directly upstream of the 24-hour BCD clock and drives its Time_in and Set_time inputs.
- Debounces two raw push-buttons.
- Snapshots the running time and lets the user edit hours, minutes and seconds in BCD, one field at a time.
- Commits the edited value with a single-cycle Set_time pulse.
- Abandons the edit after an inactivity timeout without committing.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, consecutive stable samples required before a button level is accepted
TIMEOUT_CYCLES, 32'd500000000, idle cycles in any edit state before abort to IDLE
BLINK_CYCLES, 32'd25000000, half-period of the Blink output while editing

Ports:
CLK  input  1  system clock; one clock; reset is asynchronous and active-low
Reset_n  input  1  asynchronous active-low reset
Btn_mode  input  1  raw mode button, asynchronous, active-high
Btn_inc  input  1  raw increment button, asynchronous, active-high
Btn_dec  input  1  raw decrement button; used only when CLOCK_SET_DEC_EN is defined, otherwise ignored
Time_now  input  24  current clock time, BCD {HT,HU,MT,MU,ST,SU}, 4 bits per digit
Time_in  output  24  edited time, same BCD format
Set_time  output  1  one-cycle load strobe to the clock
Edit_active  output  1  high in SET_HR, SET_MIN and SET_SEC
Field_sel  output  2  0 = none, 1 = hours, 2 = minutes, 3 = seconds
Blink  output  1  display blink enable for the selected field

Behaviour:
- Reset (Reset_n low, asynchronous):
  - state = IDLE.
  - Time_in, Set_time, Edit_active, Field_sel, Blink = 0.
  - All synchroniser, debounce, timeout and blink counters cleared.
- Button path:
  - Each button passes through a 2-FF synchroniser, then a debounce counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A one-cycle press pulse is emitted on each accepted 0->1 transition.
  - Latency from a stable raw edge to the pulse is 2 + DEBOUNCE_CYCLES cycles.
- FSM states: IDLE, SET_HR, SET_MIN, SET_SEC, COMMIT.
  - IDLE + mode pulse -> SET_HR. Same edge: Time_in <= Time_now. If captured hours > 23 or any digit is out of range, Time_in <= 0.
  - SET_HR + mode -> SET_MIN; SET_MIN + mode -> SET_SEC; SET_SEC + mode -> COMMIT.
  - COMMIT lasts exactly 1 cycle: Set_time = 1 with Time_in stable, then -> IDLE.
  - Any SET_* state with timeout counter == TIMEOUT_CYCLES-1 -> IDLE. No Set_time pulse; Time_in retains its value.
- Increment (inc pulse in a SET_* state), applied to the selected field as a 2-digit BCD value:
  - Hours: 00..23, wraps 23 -> 00 (09 -> 10, 19 -> 20).
  - Minutes and seconds: 00..59, wraps 59 -> 00.
  - Unselected digits never change.
- Timeout counter clears on any button pulse and on every state change.
- Simultaneous pulses: mode has priority; inc and dec arriving in the same cycle as mode are dropped. With inc and dec together (macro on), both are dropped.
- Inc or dec pulses in IDLE or COMMIT are ignored.
- Blink:
  - Toggles every BLINK_CYCLES while Edit_active.
  - Forced to 0 and its counter cleared otherwise.
  - Starts at 1 on entry to SET_HR.
- Field_sel is a registered function of state; it is 0 in IDLE and COMMIT.
- Outputs are registered; no combinational path from input to output.
- Reset mid-edit: returns to IDLE immediately; no Set_time is issued.

Optional Feature:
Macro CLOCK_SET_DEC_EN.
- Defined: Btn_dec gets its own synchroniser and debouncer. A dec pulse decrements the selected field with wrap: hours 00 -> 23, minutes and seconds 00 -> 59, 10 -> 09.
- Undefined: no decrement logic is built. Btn_dec stays in the port list but is unconnected internally.

Decomposition:
- Shared package clock_set_pkg holds:
  - state encoding constants: ST_IDLE, ST_SET_HR, ST_SET_MIN, ST_SET_SEC, ST_COMMIT;
  - field codes: FLD_NONE, FLD_HR, FLD_MIN, FLD_SEC;
  - limits: HR_MAX = 8'h23, MS_MAX = 8'h59.
- Sub-module btn_debounce: synchroniser, debounce counter and rising-edge pulse, parameterised by DEBOUNCE_CYCLES. Instantiated once per button.
- BCD increment/decrement is implemented as a function in the package.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64, BLINK_CYCLES=8.)
1. Reset, then Time_now=24'h123456, press mode -> state SET_HR, Time_in=24'h123456, Field_sel=1, Edit_active=1, Blink=1.
2. Bounce on Btn_inc (1-cycle glitches, shorter than 4 stable samples) -> no increment. A clean press at hours 23 -> hours 00, giving Time_in=24'h003456.
3. Complete full edit: mode x3, with minutes inc 59 -> 00 and seconds inc 09 -> 10 -> exactly one Set_time pulse. Time_in valid during the pulse; FSM back in IDLE and Field_sel=0 next cycle.
4. Enter SET_MIN, then no presses for 64 cycles -> IDLE, Set_time never asserted, Edit_active=0, Blink=0.
5. Mode and inc pulses on the same cycle in SET_HR -> move to SET_MIN, hours unchanged. Reset_n low mid-edit -> all outputs 0 asynchronously.
6. (CLOCK_SET_DEC_EN) In SET_HR with hours 00, press dec -> 23. In SET_SEC with seconds 10, press dec -> 09.
